// File: rtl/conventional_stopwatch.sv
//------------------------------------------------------------------------------
// conventional_stopwatch
//   Count-up stopwatch from 0:00.00 to MAX_MINUTES:59.99 at centisecond
//   resolution, with start/stop, clear and lap-freeze control.  The count
//   saturates at the maximum value and never wraps.
//
// Optional feature macro: STOPWATCH_DIV_EN
//   defined   : an internal divider makes the centisecond tick from clock
//               (DIV_COUNT cycles per tick, runs only while RUNNING) and the
//               tick port is ignored.
//   undefined : the tick port drives counting directly.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   tick        in   centisecond pulse (unused when STOPWATCH_DIV_EN)
//   start_stop  in   pulse, toggles run/pause
//   clear       in   pulse, back to 0:00.00 and IDLE (highest priority)
//   lap         in   pulse, toggles lap freeze of the display
//   minutes, sec_tens, sec_ones, cs_tens, cs_ones  out  displayed BCD digits
//   running     out  high while RUNNING
//   lap_active  out  high while display is frozen on a lap capture
//   max_pulse   out  one-cycle pulse on entry to SATURATED
//------------------------------------------------------------------------------
module conventional_stopwatch #(
   parameter int MAX_MINUTES = 9,
   parameter int DIV_COUNT   = 500000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick,
   input  logic       start_stop,
   input  logic       clear,
   input  logic       lap,
   output logic [3:0] minutes,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic [3:0] cs_tens,
   output logic [3:0] cs_ones,
   output logic       running,
   output logic       lap_active,
   output logic       max_pulse
);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_RUNNING   = 2'd1,
      ST_PAUSED    = 2'd2,
      ST_SATURATED = 2'd3
   } state_t;

   localparam logic [3:0] MAX_MIN_L = 4'(MAX_MINUTES);

   state_t     state_r, state_s;
   logic       running_r, lap_active_r, lap_active_s, max_pulse_r, max_pulse_s;
   logic [3:0] live_min_r, live_st_r, live_so_r, live_ct_r, live_co_r;
   logic [3:0] live_min_s, live_st_s, live_so_s, live_ct_s, live_co_s;
   logic [3:0] lap_min_r, lap_st_r, lap_so_r, lap_ct_r, lap_co_r;
   logic [3:0] lap_min_s, lap_st_s, lap_so_s, lap_ct_s, lap_co_s;
   logic       tick_s, at_max_s;

`ifdef STOPWATCH_DIV_EN
   localparam int DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   logic [DIV_W-1:0] div_r;
   logic             unused_tick_s;

   assign unused_tick_s = tick;
   assign tick_s        = (div_r == DIV_W'(DIV_COUNT - 1));

   // Centisecond divider; holds while not running so a pause keeps the partial tick.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         div_r <= '0;
      end else if (clear) begin
         div_r <= '0;
      end else if (state_r == ST_RUNNING) begin
         div_r <= tick_s ? '0 : div_r + 1'b1;
      end else begin
         div_r <= div_r;
      end
   end
`else
   assign tick_s = tick;
`endif

   assign at_max_s = (live_min_r == MAX_MIN_L) && (live_st_r == 4'd5) &&
                     (live_so_r == 4'd9) && (live_ct_r == 4'd9) && (live_co_r == 4'd9);

   // Next-state, counting, lap capture and saturation pulse.
   always_comb begin
      state_s      = state_r;
      lap_active_s = lap_active_r;
      max_pulse_s  = 1'b0;
      live_min_s = live_min_r; live_st_s = live_st_r; live_so_s = live_so_r;
      live_ct_s  = live_ct_r;  live_co_s = live_co_r;
      lap_min_s  = lap_min_r;  lap_st_s  = lap_st_r;  lap_so_s  = lap_so_r;
      lap_ct_s   = lap_ct_r;   lap_co_s  = lap_co_r;

      if (clear) begin
         state_s      = ST_IDLE;
         lap_active_s = 1'b0;
         live_min_s = 4'd0; live_st_s = 4'd0; live_so_s = 4'd0; live_ct_s = 4'd0; live_co_s = 4'd0;
         lap_min_s  = 4'd0; lap_st_s  = 4'd0; lap_so_s  = 4'd0; lap_ct_s  = 4'd0; lap_co_s  = 4'd0;
      end else begin
         // Count uses the state at this edge; saturation beats a same-cycle start_stop.
         if (tick_s && (state_r == ST_RUNNING)) begin
            if (at_max_s) begin
               max_pulse_s = 1'b1;
            end else if (live_co_r != 4'd9) begin
               live_co_s = live_co_r + 4'd1;
            end else begin
               live_co_s = 4'd0;
               if (live_ct_r != 4'd9) begin
                  live_ct_s = live_ct_r + 4'd1;
               end else begin
                  live_ct_s = 4'd0;
                  if (live_so_r != 4'd9) begin
                     live_so_s = live_so_r + 4'd1;
                  end else begin
                     live_so_s = 4'd0;
                     if (live_st_r != 4'd5) begin
                        live_st_s = live_st_r + 4'd1;
                     end else begin
                        // Not at max here, so minutes < MAX_MINUTES.
                        live_st_s  = 4'd0;
                        live_min_s = live_min_r + 4'd1;
                     end
                  end
               end
            end
         end else begin
            max_pulse_s = 1'b0;
         end

         if (max_pulse_s) begin
            state_s = ST_SATURATED;
         end else if (start_stop) begin
            case (state_r)
               ST_IDLE:      state_s = ST_RUNNING;
               ST_RUNNING:   state_s = ST_PAUSED;
               ST_PAUSED:    state_s = ST_RUNNING;
               ST_SATURATED: state_s = ST_SATURATED;
               default:      state_s = ST_IDLE;
            endcase
         end else begin
            state_s = state_r;
         end

         // Lap captures the pre-increment live value.
         if (lap && (state_r != ST_IDLE)) begin
            if (!lap_active_r) begin
               lap_active_s = 1'b1;
               lap_min_s = live_min_r; lap_st_s = live_st_r; lap_so_s = live_so_r;
               lap_ct_s  = live_ct_r;  lap_co_s = live_co_r;
            end else begin
               lap_active_s = 1'b0;
            end
         end else begin
            lap_active_s = lap_active_r;
         end
      end
   end

   // State and digit registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         running_r    <= 1'b0;
         lap_active_r <= 1'b0;
         max_pulse_r  <= 1'b0;
         live_min_r <= 4'd0; live_st_r <= 4'd0; live_so_r <= 4'd0; live_ct_r <= 4'd0; live_co_r <= 4'd0;
         lap_min_r  <= 4'd0; lap_st_r  <= 4'd0; lap_so_r  <= 4'd0; lap_ct_r  <= 4'd0; lap_co_r  <= 4'd0;
      end else begin
         state_r      <= state_s;
         running_r    <= (state_s == ST_RUNNING);
         lap_active_r <= lap_active_s;
         max_pulse_r  <= max_pulse_s;
         live_min_r <= live_min_s; live_st_r <= live_st_s; live_so_r <= live_so_s;
         live_ct_r  <= live_ct_s;  live_co_r <= live_co_s;
         lap_min_r  <= lap_min_s;  lap_st_r  <= lap_st_s;  lap_so_r  <= lap_so_s;
         lap_ct_r   <= lap_ct_s;   lap_co_r  <= lap_co_s;
      end
   end

   assign minutes    = lap_active_r ? lap_min_r : live_min_r;
   assign sec_tens   = lap_active_r ? lap_st_r  : live_st_r;
   assign sec_ones   = lap_active_r ? lap_so_r  : live_so_r;
   assign cs_tens    = lap_active_r ? lap_ct_r  : live_ct_r;
   assign cs_ones    = lap_active_r ? lap_co_r  : live_co_r;
   assign running    = running_r;
   assign lap_active = lap_active_r;
   assign max_pulse  = max_pulse_r;

endmodule

// File: tb/tb_conventional_stopwatch.sv
//------------------------------------------------------------------------------
// tb_conventional_stopwatch
//   Directed bench.  A model keeps elapsed time as an integer count of
//   centiseconds and derives the expected BCD digits arithmetically; it is
//   compared with the DUT every cycle, and literal expectations pin key values.
//------------------------------------------------------------------------------
module tb_conventional_stopwatch;

   localparam int MAXV = 9 * 6000 + 5999;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_SAT = 3;

   logic       clock = 1'b0;
   logic       reset, tick, start_stop, clear, lap;
   logic [3:0] minutes, sec_tens, sec_ones, cs_tens, cs_ones;
   logic       running, lap_active, max_pulse;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: elapsed centiseconds, lap capture, state code, pulse.
   int m_v, m_lapv, m_st;
   bit m_la, m_mp;

   conventional_stopwatch #(.MAX_MINUTES(9), .DIV_COUNT(500000)) dut (
      .clock(clock), .reset(reset), .tick(tick), .start_stop(start_stop),
      .clear(clear), .lap(lap), .minutes(minutes), .sec_tens(sec_tens),
      .sec_ones(sec_ones), .cs_tens(cs_tens), .cs_ones(cs_ones),
      .running(running), .lap_active(lap_active), .max_pulse(max_pulse)
   );

   always #5 clock = ~clock;

   function automatic logic [19:0] to_bcd(int v);
      to_bcd = {4'(v / 6000), 4'(((v / 100) % 60) / 10), 4'((v / 100) % 10),
                4'((v % 100) / 10), 4'(v % 10)};
   endfunction

   function automatic logic [19:0] dut_disp();
      dut_disp = {minutes, sec_tens, sec_ones, cs_tens, cs_ones};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_zero();
      m_v = 0; m_lapv = 0; m_st = S_IDLE; m_la = 1'b0; m_mp = 1'b0;
   endtask

   task automatic model_step(input bit ss, input bit cl, input bit lp, input bit tk);
      int pre, nst;
      if (cl) begin
         model_zero();
      end else begin
         pre  = m_v;
         nst  = m_st;
         m_mp = 1'b0;
         if (tk && m_st == S_RUN) begin
            if (m_v == MAXV) begin
               nst = S_SAT; m_mp = 1'b1;
            end else begin
               m_v = m_v + 1;
            end
         end
         if (ss && !m_mp) begin
            if (m_st == S_IDLE || m_st == S_PAUSE) nst = S_RUN;
            else if (m_st == S_RUN) nst = S_PAUSE;
         end
         if (lp && m_st != S_IDLE) begin
            if (!m_la) begin
               m_lapv = pre; m_la = 1'b1;
            end else begin
               m_la = 1'b0;
            end
         end
         m_st = nst;
      end
   endtask

   task automatic compare_model();
      chk("display",    32'(dut_disp()), 32'(to_bcd(m_la ? m_lapv : m_v)));
      chk("running",    32'(running),    32'(m_st == S_RUN));
      chk("lap_active", 32'(lap_active), 32'(m_la));
      chk("max_pulse",  32'(max_pulse),  32'(m_mp));
   endtask

   // One clock cycle with the given input pulses, then a model compare.
   task automatic cyc(input bit ss, input bit cl, input bit lp, input bit tk);
      start_stop = ss; clear = cl; lap = lp; tick = tk;
      @(posedge clock);
      if (reset) model_zero();
      else       model_step(ss, cl, lp, tk);
      @(negedge clock);
      start_stop = 1'b0; clear = 1'b0; lap = 1'b0; tick = 1'b0;
      compare_model();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      reset = 1'b0; tick = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
      model_zero();
      #1 reset = 1'b1;
      @(negedge clock);
      compare_model();
      chk("reset_digits", 32'(dut_disp()), 32'h0);
      reset = 1'b0;

      // Start, count, pause with a coincident tick (counted).
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      ticks(99);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      chk("run_100", 32'(dut_disp()), 32'h00100);
      chk("paused_running", 32'(running), 32'h0);
      ticks(50);
      chk("paused_hold", 32'(dut_disp()), 32'h00100);
      // Resume with a coincident tick (not counted).
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      chk("resume_no_count", 32'(dut_disp()), 32'h00100);
      chk("resume_running", 32'(running), 32'h1);

      // Lap freeze at 0:03.21.
      ticks(221);
      chk("pre_lap", 32'(dut_disp()), 32'h00321);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      ticks(10);
      chk("lap_frozen", 32'(dut_disp()), 32'h00321);
      chk("lap_active_on", 32'(lap_active), 32'h1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("lap_released", 32'(dut_disp()), 32'h00331);
      chk("lap_active_off", 32'(lap_active), 32'h0);

      // clear beats start_stop and tick at 0:05.00.
      ticks(169);
      chk("at_5s", 32'(dut_disp()), 32'h00500);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
      chk("clear_prio", 32'(dut_disp()), 32'h0);
      chk("clear_idle", 32'(running), 32'h0);
      ticks(3);
      chk("idle_no_count", 32'(dut_disp()), 32'h0);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("idle_lap_ignored", 32'(lap_active), 32'h0);

      // Asynchronous reset mid-count at 0:12.34.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      ticks(1234);
      chk("at_12_34", 32'(dut_disp()), 32'h01234);
      #2 reset = 1'b1;
      #1;
      model_zero();
      chk("async_reset_digits", 32'(dut_disp()), 32'h0);
      chk("async_reset_running", 32'(running), 32'h0);
      chk("async_reset_lap", 32'(lap_active), 32'h0);
      @(negedge clock);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;

      // Full carry 0:59.99 -> 1:00.00, then run to saturation.
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      ticks(5999);
      chk("at_59_99", 32'(dut_disp()), 32'h05999);
      ticks(1);
      chk("roll_1_00_00", 32'(dut_disp()), 32'h10000);
      ticks(53999);
      chk("at_max", 32'(dut_disp()), 32'h95999);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("sat_hold", 32'(dut_disp()), 32'h95999);
      chk("sat_pulse", 32'(max_pulse), 32'h1);
      chk("sat_not_running", 32'(running), 32'h0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("sat_pulse_once", 32'(max_pulse), 32'h0);
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      chk("sat_ss_ignored", 32'(running), 32'h0);
      chk("sat_no_wrap", 32'(dut_disp()), 32'h95999);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk("sat_lap", 32'(lap_active), 32'h1);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk("sat_clear", 32'(dut_disp()), 32'h0);
      chk("sat_clear_lap", 32'(lap_active), 32'h0);
      ticks(2);
      chk("after_clear_idle", 32'(dut_disp()), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/conventional_stopwatch.md
Name: conventional_stopwatch

Overview:
- Count-up companion to the countdown timer: measures elapsed time from 0:00.00 up to MAX_MINUTES:59.99 at centisecond resolution.
- Provides start/stop, clear and lap-freeze control.
- Drives five BCD digit outputs that feed the existing hex_decoder instances.
- Asserts a one-cycle pulse when it saturates at the maximum value.

Parameters:
- MAX_MINUTES, 9, highest minutes value (1-9); count saturates at MAX_MINUTES:59.99.
- DIV_COUNT, 500000, clock cycles per centisecond tick; used only when STOPWATCH_DIV_EN is defined.

Ports:
- clock  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- tick  input  1  one-cycle centisecond pulse from the rate divider; ignored when STOPWATCH_DIV_EN is defined
- start_stop  input  1  one-cycle pulse, already synchronised; toggles run/pause
- clear  input  1  one-cycle pulse; returns to 0:00.00 and IDLE
- lap  input  1  one-cycle pulse; toggles lap freeze of the displayed value
- minutes  output  4  displayed minutes digit, BCD
- sec_tens  output  4  displayed seconds tens digit, 0-5
- sec_ones  output  4  displayed seconds ones digit, 0-9
- cs_tens  output  4  displayed centiseconds tens digit, 0-9
- cs_ones  output  4  displayed centiseconds ones digit, 0-9
- running  output  1  high while in RUNNING
- lap_active  output  1  high while the display is frozen on a lap capture
- max_pulse  output  1  one-cycle pulse on entry to SATURATED

Behaviour:
- Reset (asynchronous): all live and lap digits 0, state IDLE, running=0, lap_active=0, max_pulse=0.
- States: IDLE, RUNNING, PAUSED, SATURATED.
- Transitions on start_stop:
  - IDLE->RUNNING
  - RUNNING->PAUSED
  - PAUSED->RUNNING
  - ignored in SATURATED
- clear from any state: next state IDLE, live digits 0, lap digits 0, lap_active 0.
- clear has priority over start_stop, lap and tick in the same cycle.
- Counting:
  - The live count increments by 0.01 s on a tick edge only if the state at that edge is RUNNING.
  - New value visible the cycle after the tick (1-cycle latency).
- Carry chain:
  - cs_ones 9->0 carries into cs_tens
  - cs_tens 9->0 carries into sec_ones
  - sec_ones 9->0 carries into sec_tens
  - sec_tens 5->0 carries into minutes
  - All carries resolve in one cycle.
- Saturation:
  - A tick while RUNNING and live = MAX_MINUTES:59.99 leaves the count unchanged, moves to SATURATED and asserts max_pulse for exactly one cycle.
  - The count never wraps.
  - Only clear or reset exits SATURATED.
- Simultaneous events:
  - start_stop and tick together while RUNNING: the tick is counted, then the state becomes PAUSED.
  - start_stop and tick together in PAUSED: the tick is not counted, then the state becomes RUNNING.
- Lap:
  - Honoured in RUNNING, PAUSED and SATURATED; ignored in IDLE.
  - If lap_active=0: copy the live digits into the lap registers (the pre-increment value if tick coincides) and set lap_active=1.
  - If lap_active=1: clear lap_active.
  - The live count continues regardless of lap.
- Display outputs: lap_active ? lap registers : live registers. Outputs are a direct mux of registers, with no extra latency.
- running = (state==RUNNING); running is registered along with the state.
- Digits never hold illegal BCD values; sec_tens never exceeds 5 and minutes never exceeds MAX_MINUTES.

Optional Feature:
- Macro name: STOPWATCH_DIV_EN.
- Defined:
  - An internal divider counts 0..DIV_COUNT-1 and generates the tick internally on the terminal count.
  - The tick port is ignored.
  - The divider resets to 0 on reset or clear and runs only while RUNNING, so pausing preserves the partial centisecond.
- Undefined:
  - No divider logic is present and the tick port drives counting directly.

Test Plan:
- Reset asserted mid-count at 0:12.34 -> all digit outputs 0 immediately (asynchronous), running=0, lap_active=0.
- start_stop, then 100 ticks -> 0:01.00; start_stop, then 50 ticks -> still 0:01.00, running=0.
- Preload by ticking to 0:59.99, then 1 tick -> 1:00.00 with every digit rolling in the same cycle.
- Run to 9:59.99, then 1 tick -> stays 9:59.99, max_pulse high for exactly 1 cycle, state SATURATED; further start_stop ignored; clear -> 0:00.00, IDLE.
- At 0:03.21, lap, then 10 ticks -> outputs show 0:03.21; lap again -> outputs show 0:03.31, lap_active=0.
- clear, start_stop and tick in the same cycle while RUNNING at 0:05.00 -> 0:00.00, IDLE, running=0.
